// File: rtl/scan_pkg.sv
// Shared types and default widths for the scan shift-register driver.
package scan_pkg;

   localparam int unsigned DIN_N_DEF  = 160;
   localparam int unsigned DOUT_N_DEF = 160;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } scan_state_e;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load shift register presenting its MSB; feeds the serial tx path.
module scan_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb_c
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_shl_c;

   if (W == 1) begin : g_one
      assign sr_shl_c = '0;
   end else begin : g_multi
      assign sr_shl_c = {sr_q[W-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (load) begin
         sr_q <= din;
      end else if (shift) begin
         sr_q <= sr_shl_c;
      end
   end

   assign msb_c = sr_q[W-1];

endmodule

// File: rtl/scan_shr_driver.sv
// Drives one write/strobe/read-back transaction against an external scan shift register.
module scan_shr_driver
   import scan_pkg::*;
#(
   parameter int unsigned DIN_N  = DIN_N_DEF,
   parameter int unsigned DOUT_N = DOUT_N_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIN_N-1:0]  wdata,
   output logic              busy,
   output logic              done,
   output logic [DOUT_N-1:0] rdata,
   output logic              so,
   output logic              stb,
   input  logic              si
);

   localparam int unsigned CNT_MAX = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   scan_state_e       state_q;
   scan_state_e       state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              load_c;
   logic              shift_c;
   logic              tx_msb_c;
   logic              cap_q;
   logic [DOUT_N-1:0] rx_q;
   logic [DOUT_N-1:0] rx_shl_c;

   scan_shreg #(
      .W (DIN_N)
   ) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_c),
      .shift (shift_c),
      .din   (wdata),
      .msb_c (tx_msb_c)
   );

   if (DOUT_N == 1) begin : g_rx_one
      assign rx_shl_c = si;
   end else begin : g_rx_multi
      assign rx_shl_c = {rx_q[DOUT_N-2:0], si};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_c  = 1'b0;
      shift_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load_c  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_c = 1'b1;
            if (cnt_q == CNT_W'(DIN_N - 1)) begin
               cnt_d   = '0;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STROBE: begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (cnt_q == CNT_W'(DOUT_N - 1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pins are registered from the current state, so they trail it by one cycle;
   // rx sampling follows the pin timeline via cap_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         so    <= 1'b0;
         stb   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         cap_q <= 1'b0;
         rx_q  <= '0;
         rdata <= '0;
      end else begin
         so    <= (state_q == ST_SHIFT) && tx_msb_c;
         stb   <= (state_q == ST_STROBE);
         busy  <= (state_q == ST_SHIFT) || (state_q == ST_STROBE) ||
                  (state_q == ST_CAPTURE);
         done  <= (state_q == ST_DONE);
         cap_q <= (state_q == ST_CAPTURE);
         if (cap_q) begin
            rx_q <= rx_shl_c;
         end
         if (state_q == ST_DONE) begin
            rdata <= rx_shl_c;
         end
      end
   end

endmodule

// File: tb/tb_scan_shr_driver.sv
// Directed bench: 8/8 inverting target, 1/1 with si tied high, 160/160 loopback target.
module tb_scan_shr_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_bc, tgt_rst_n;

   logic         start_a, busy_a, done_a, so_a, stb_a, si_a;
   logic [7:0]   wdata_a, rdata_a;
   logic         start_b, busy_b, done_b, so_b, stb_b;
   logic [0:0]   wdata_b, rdata_b;
   logic         start_c, busy_c, done_c, so_c, stb_c, si_c;
   logic [159:0] wdata_c, rdata_c;

   int n_checks = 0;
   int n_errors = 0;

   scan_shr_driver #(.DIN_N(8), .DOUT_N(8)) u_dut_a (
      .clk(clk), .rst_n(rst_a), .start(start_a), .wdata(wdata_a), .busy(busy_a),
      .done(done_a), .rdata(rdata_a), .so(so_a), .stb(stb_a), .si(si_a)
   );

   scan_shr_driver #(.DIN_N(1), .DOUT_N(1)) u_dut_b (
      .clk(clk), .rst_n(rst_bc), .start(start_b), .wdata(wdata_b), .busy(busy_b),
      .done(done_b), .rdata(rdata_b), .so(so_b), .stb(stb_b), .si(1'b1)
   );

   scan_shr_driver u_dut_c (
      .clk(clk), .rst_n(rst_bc), .start(start_c), .wdata(wdata_c), .busy(busy_c),
      .done(done_c), .rdata(rdata_c), .so(so_c), .stb(stb_c), .si(si_c)
   );

   // Target A: serial-in register, parallel latch on stb, returns ~latched word MSB first
   logic [7:0] ta_sr, ta_par, ta_cap;
   always_ff @(posedge clk or negedge tgt_rst_n) begin
      if (!tgt_rst_n) begin
         ta_sr <= '0; ta_par <= '0; ta_cap <= '0;
      end else begin
         ta_sr <= {ta_sr[6:0], so_a};
         if (stb_a) begin
            ta_par <= ta_sr;
            ta_cap <= ~ta_par;
         end else begin
            ta_cap <= {ta_cap[6:0], 1'b0};
         end
      end
   end
   assign si_a = ta_cap[7];

   // Target C: same structure, identity return path
   logic [159:0] tc_sr, tc_par, tc_cap;
   always_ff @(posedge clk or negedge tgt_rst_n) begin
      if (!tgt_rst_n) begin
         tc_sr <= '0; tc_par <= '0; tc_cap <= '0;
      end else begin
         tc_sr <= {tc_sr[158:0], so_c};
         if (stb_c) begin
            tc_par <= tc_sr;
            tc_cap <= tc_par;
         end else begin
            tc_cap <= {tc_cap[158:0], 1'b0};
         end
      end
   end
   assign si_c = tc_cap[159];

   logic stb_a_p = 1'b0, stb_b_p = 1'b0, stb_c_p = 1'b0, stb_dbl = 1'b0;
   always @(posedge clk) begin
      if ((stb_a && stb_a_p) || (stb_b && stb_b_p) || (stb_c && stb_c_p)) stb_dbl <= 1'b1;
      stb_a_p <= stb_a;
      stb_b_p <= stb_b;
      stb_c_p <= stb_c;
   end

   assert property (@(posedge clk) !(stb_c && $past(stb_c)));

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Launch one A transaction from a negedge and record pin activity per cycle j after acceptance
   task automatic txn_a(input logic [7:0] w, output int done_at, output int stb_at,
                        output int stb_cnt, output int busy_cnt, output int done_cnt,
                        output logic [7:0] so_seq);
      done_at = -1; stb_at = -1; stb_cnt = 0; busy_cnt = 0; done_cnt = 0; so_seq = '0;
      wdata_a = w;
      start_a = 1'b1;
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         if (j >= 1 && j <= 8) so_seq = {so_seq[6:0], so_a};
         if (stb_a)  begin stb_cnt++;  stb_at  = j; end
         if (done_a) begin done_cnt++; done_at = j; end
         if (busy_a) busy_cnt++;
         if (j == 0) start_a = 1'b0;
      end
   endtask

   task automatic txn_c(input logic [159:0] w, output int lat);
      wdata_c = w;
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      lat = 0;
      while (!done_c && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done_at, stb_at, stb_cnt, busy_cnt, done_cnt, rises, r1, r2, lat;
      logic [7:0] so_seq;
      logic prev;
      logic [159:0] w1, w2;

      rst_a = 1'b0; rst_bc = 1'b0; tgt_rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      wdata_a = '0; wdata_b = '0; wdata_c = '0;
      repeat (3) @(negedge clk);
      check("rst_pins_a", {so_a, stb_a, busy_a, done_a}, 4'b0000);
      check("rst_rdata_a", rdata_a, 8'h00);
      check("rst_pins_c", {so_c, stb_c, busy_c, done_c}, 4'b0000);
      rst_a = 1'b1; rst_bc = 1'b1; tgt_rst_n = 1'b1;

      // First start right at reset release; pattern A5
      txn_a(8'hA5, done_at, stb_at, stb_cnt, busy_cnt, done_cnt, so_seq);
      check("so_seq_a5", so_seq, 8'hA5);
      check("stb_pos", stb_at, 9);
      check("stb_cnt", stb_cnt, 1);
      check("done_lat", done_at, 18);
      check("done_cnt", done_cnt, 1);
      check("busy_cycles", busy_cnt, 17);
      check("rdata_first", rdata_a, 8'hFF);

      txn_a(8'h3C, done_at, stb_at, stb_cnt, busy_cnt, done_cnt, so_seq);
      check("so_seq_3c", so_seq, 8'h3C);
      check("rdata_after_3c", rdata_a, 8'h5A);
      txn_a(8'h0F, done_at, stb_at, stb_cnt, busy_cnt, done_cnt, so_seq);
      check("rdata_after_0f", rdata_a, 8'hC3);

      // start held high continuously
      wdata_a = 8'h55;
      start_a = 1'b1;
      rises = 0; r1 = -1; r2 = -1; done_cnt = 0; prev = 1'b0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (busy_a && !prev) begin
            rises++;
            if (rises == 1) r1 = c;
            if (rises == 2) r2 = c;
         end
         if (done_a) done_cnt++;
         prev = busy_a;
      end
      start_a = 1'b0;
      repeat (25) @(negedge clk);
      check("held_first_rise", r1, 1);
      check("held_spacing", r2 - r1, 19);
      check("held_rises", rises, 4);
      check("held_dones", done_cnt, 3);
      check("held_rdata", rdata_a, 8'hAA);

      // Reset in the middle of SHIFT
      wdata_a = 8'h96;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", busy_a, 1'b1);
      rst_a = 1'b0;
      #1;
      check("async_rst_pins", {so_a, stb_a, busy_a, done_a}, 4'b0000);
      check("async_rst_rdata", rdata_a, 8'h00);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      done_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done_a) done_cnt++;
         if (busy_a) busy_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_no_busy", busy_cnt, 0);
      txn_a(8'h81, done_at, stb_at, stb_cnt, busy_cnt, done_cnt, so_seq);
      check("post_rst_lat", done_at, 18);
      check("post_rst_rdata", rdata_a, 8'hAA);
      txn_a(8'h00, done_at, stb_at, stb_cnt, busy_cnt, done_cnt, so_seq);
      check("post_rst_rdata2", rdata_a, 8'h7E);

      // 1/1 widths, si tied high
      wdata_b = 1'b1;
      start_b = 1'b1;
      done_at = -1; stb_at = -1; busy_cnt = 0; prev = 1'b0;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j == 1) prev = so_b;
         if (stb_b)  stb_at = j;
         if (done_b) done_at = j;
         if (busy_b) busy_cnt++;
         if (j == 0) start_b = 1'b0;
      end
      check("b_so", prev, 1'b1);
      check("b_stb_pos", stb_at, 2);
      check("b_done_lat", done_at, 4);
      check("b_busy_cycles", busy_cnt, 3);
      check("b_rdata", rdata_b, 1'b1);

      // 160/160 loopback
      w1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      w2 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      txn_c(w1, lat);
      check("c_lat1", lat, 322);
      check("c_rdata1", rdata_c, 160'h0);
      repeat (2) @(negedge clk);
      txn_c(w2, lat);
      check("c_lat2", lat, 322);
      check("c_rdata2", rdata_c, w1);
      @(negedge clk);
      check("c_idle_busy", busy_c, 1'b0);

      check("stb_single_cycle", stb_dbl, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
